rtermcal_ctrl: RTL

Digital calibration sequencer for the 1.8 V termination-calibration pad cell. On request it steps the cell through single-ended (SGIO) calibration with a linear thermometer sweep, then LVDS calibration with a 4-bit successive-approximation search. Each code is held for a programmable settle time before the cell's comparator result is sampled. The resulting codes are latched for distribution to the IO ring's termination trim inputs.

---
 rtl/rtermcal_ctrl_pkg.sv | 30 +++
 rtl/rtermcal_sync2.sv | 26 ++
 rtl/rtermcal_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rtermcal_ctrl_pkg.sv
// rtl/rtermcal_ctrl_pkg.sv - shared types, constants and helpers for the termination-calibration sequencer
package rtermcal_ctrl_pkg;

    localparam int CODE_W  = 4;
    localparam int THERM_W = 15;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_SGIO = 2'b01;
    localparam logic [1:0] MODE_LVDS = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SG_SET,
        ST_SG_WAIT,
        ST_SG_EVAL,
        ST_LV_SET,
        ST_LV_WAIT,
        ST_LV_EVAL,
        ST_LV_CHK,
        ST_DONE
    } state_e;

    // n lowest segments on; computed one bit wider so n=15 does not wrap
    function automatic logic [THERM_W-1:0] therm_from_count(input logic [CODE_W-1:0] n);
        logic [THERM_W:0] t;
        t = ((THERM_W+1)'(1) << n) - (THERM_W+1)'(1);
        return t[THERM_W-1:0];
    endfunction

endpackage

// File: rtl/rtermcal_sync2.sv
// rtl/rtermcal_sync2.sv - two-flop synchronizer for the asynchronous comparator outputs
module rtermcal_sync2 #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rtermcal_ctrl.sv
// rtl/rtermcal_ctrl.sv - SGIO thermometer sweep then LVDS SAR calibration sequencer
module rtermcal_ctrl
    import rtermcal_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               en_sgio_i,
    input  logic               en_lvds_i,
    input  logic               abort_i,
    input  logic [1:0]         cal_result_i,
    output logic [1:0]         cal_mode_o,
    output logic [THERM_W-1:0] cal_iosg_o,
    output logic [CODE_W-1:0]  cal_lvds_o,
    output logic [CODE_W-1:0]  sgio_code_o,
    output logic [CODE_W-1:0]  lvds_code_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         err_o
);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CODE_W-1:0]  sg_n_q, sg_n_d;
    logic [CODE_W-1:0]  sar_q, sar_d;
    logic [1:0]         bit_q, bit_d;
    logic               chk_q, chk_d;
    logic               en_sg_q, en_sg_d;
    logic               en_lv_q, en_lv_d;
    logic [1:0]         mode_q, mode_d;
    logic [THERM_W-1:0] iosg_q, iosg_d;
    logic [CODE_W-1:0]  lvds_q, lvds_d;
    logic [CODE_W-1:0]  sgio_code_q, sgio_code_d;
    logic [CODE_W-1:0]  lvds_code_q, lvds_code_d;
    logic [1:0]         err_q, err_d;
    logic [1:0]         res;
    logic [CODE_W-1:0]  sar_n;
    logic               go_sg, go_lv, sg_done;

    rtermcal_sync2 #(.WIDTH(2)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cal_result_i),
        .q_o    (res)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sg_n_d      = sg_n_q;
        sar_d       = sar_q;
        bit_d       = bit_q;
        chk_d       = chk_q;
        en_sg_d     = en_sg_q;
        en_lv_d     = en_lv_q;
        mode_d      = mode_q;
        iosg_d      = iosg_q;
        lvds_d      = lvds_q;
        sgio_code_d = sgio_code_q;
        lvds_code_d = lvds_code_q;
        err_d       = err_q;
        sar_n       = sar_q;
        go_sg       = 1'b0;
        go_lv       = 1'b0;
        sg_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_d   = 2'b00;
                    en_sg_d = en_sgio_i;
                    en_lv_d = en_lvds_i;
                    if (en_sgio_i) begin
                        sg_n_d = '0;
                        go_sg  = 1'b1;
                    end else if (en_lvds_i) begin
                        go_lv = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SG_SET, ST_LV_SET: begin
                cnt_d   = '0;
                state_d = (state_q == ST_SG_SET) ? ST_SG_WAIT : ST_LV_WAIT;
            end
            ST_SG_WAIT, ST_LV_WAIT: begin
                if (cnt_q == 8'(SETTLE_CYC - 1)) begin
                    if (state_q == ST_SG_WAIT) state_d = ST_SG_EVAL;
                    else                       state_d = chk_q ? ST_LV_CHK : ST_LV_EVAL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SG_EVAL: begin
                if (res[0]) begin
                    sgio_code_d = sg_n_q;
                    sg_done     = 1'b1;
                end else if (sg_n_q == 4'd15) begin
                    sgio_code_d = 4'd15;
                    err_d[0]    = 1'b1;
                    sg_done     = 1'b1;
                end else begin
                    sg_n_d = sg_n_q + 4'd1;
                    go_sg  = 1'b1;
                end
            end
            ST_LV_EVAL: begin
                // comparator high means the trial overshot: drop the bit
                sar_n   = res[1] ? sar_q : (sar_q | (4'b0001 << bit_q));
                sar_d   = sar_n;
                state_d = ST_LV_SET;
                if (bit_q == 2'd0) begin
                    chk_d  = 1'b1;
                    lvds_d = sar_n;
                end else begin
                    bit_d  = bit_q - 2'd1;
                    lvds_d = sar_n | (4'b0001 << (bit_q - 2'd1));
                end
            end
            ST_LV_CHK: begin
                if (res[1]) begin
                    lvds_code_d = 4'd0;
                end else if (sar_q == 4'd15) begin
                    lvds_code_d = 4'd15;
                    err_d[1]    = 1'b1;
                end else begin
                    lvds_code_d = sar_q + 4'd1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (sg_done) begin
            if (en_lv_q) go_lv = 1'b1;
            else         state_d = ST_DONE;
        end
        if (go_sg) begin
            state_d = ST_SG_SET;
            mode_d  = MODE_SGIO;
            iosg_d  = therm_from_count(sg_n_d);
        end
        if (go_lv) begin
            state_d = ST_LV_SET;
            mode_d  = MODE_LVDS;
            iosg_d  = '0;
            sar_d   = '0;
            bit_d   = 2'd3;
            chk_d   = 1'b0;
            lvds_d  = 4'b1000;
        end
        if (abort_i) begin
            state_d     = ST_IDLE;
            sgio_code_d = sgio_code_q;
            lvds_code_d = lvds_code_q;
            err_d       = err_q;
        end
        if (state_d == ST_IDLE) begin
            mode_d = MODE_OFF;
            iosg_d = '0;
            lvds_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sg_n_q      <= '0;
            sar_q       <= '0;
            bit_q       <= '0;
            chk_q       <= 1'b0;
            en_sg_q     <= 1'b0;
            en_lv_q     <= 1'b0;
            mode_q      <= MODE_OFF;
            iosg_q      <= '0;
            lvds_q      <= '0;
            sgio_code_q <= '0;
            lvds_code_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sg_n_q      <= sg_n_d;
            sar_q       <= sar_d;
            bit_q       <= bit_d;
            chk_q       <= chk_d;
            en_sg_q     <= en_sg_d;
            en_lv_q     <= en_lv_d;
            mode_q      <= mode_d;
            iosg_q      <= iosg_d;
            lvds_q      <= lvds_d;
            sgio_code_q <= sgio_code_d;
            lvds_code_q <= lvds_code_d;
            err_q       <= err_d;
        end
    end

    assign cal_mode_o  = mode_q;
    assign cal_iosg_o  = iosg_q;
    assign cal_lvds_o  = lvds_q;
    assign sgio_code_o = sgio_code_q;
    assign lvds_code_o = lvds_code_q;
    assign err_o       = err_q;
    assign done_o      = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
